spi_arbiter: RTL

- Shares the single SPI master (digital pots, trigger DAC, EEPROM) between two requesters.
  - Requester 0: host command path.
  - Requester 1: autonomous calibration/refresh sequencer.
- Buffers one request per requester, arbitrates round-robin and launches the transaction.
- Returns per-requester completion with the EEPROM read byte; an optional watchdog aborts hung transfers.
- Sits inside the digital core, between the requesters and the SPI peripheral.

---
 rtl/spi_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master between two requesters
// Optional watchdog abort of hung transfers: define SPI_TIMEOUT_EN.

module spi_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [2:0]  ss0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [2:0]  ss1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic        ovf0,
    output logic        ovf1,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        wrt_SPI,
    output logic [15:0] SPI_data,
    output logic [2:0]  ss,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data
);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic        state_q, state_d;
    logic        last_q, last_d;
    logic        cur_q, cur_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic [2:0]  sss0_q, sss0_d, sss1_q, sss1_d;
    logic [15:0] sdat0_q, sdat0_d, sdat1_q, sdat1_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err_q, err_d, ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic        wrt_q, wrt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] spi_data_q, spi_data_d;
    logic [2:0]  ss_q, ss_d;

    logic grant0, grant1, launch, complete, expire, finish, cap0, cap1;

    // last_q names the requester served most recently in a tie; the other one wins the next tie
    assign grant0   = (state_q == ST_IDLE) && pend0_q && (!pend1_q || last_q);
    assign grant1   = (state_q == ST_IDLE) && pend1_q && (!pend0_q || !last_q);
    assign launch   = grant0 || grant1;
    // wrt_q marks the first WAIT cycle, in which SPI_done is not yet meaningful
    assign complete = (state_q == ST_WAIT) && !wrt_q && SPI_done;

`ifdef SPI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !complete;
    assign cnt_d  = launch ? '0 : ((state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    assign finish = complete || expire;
    // a slot being granted this cycle counts as free, so a same-cycle strobe refills it
    assign cap0   = req0 && (!pend0_q || grant0);
    assign cap1   = req1 && (!pend1_q || grant1);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cur_d      = cur_q;
        spi_data_d = spi_data_q;
        ss_d       = ss_q;
        rdata_d    = complete ? EEP_data : rdata_q;
        if (launch) begin
            state_d    = ST_WAIT;
            cur_d      = grant1;
            if (pend0_q && pend1_q) last_d = grant1;
            spi_data_d = grant1 ? sdat1_q : sdat0_q;
            ss_d       = grant1 ? sss1_q : sss0_q;
        end else if (finish) begin
            state_d = ST_IDLE;
        end
        pend0_d = cap0 ? 1'b1 : (grant0 ? 1'b0 : pend0_q);
        pend1_d = cap1 ? 1'b1 : (grant1 ? 1'b0 : pend1_q);
        sss0_d  = cap0 ? ss0 : sss0_q;
        sss1_d  = cap1 ? ss1 : sss1_q;
        sdat0_d = cap0 ? data0 : sdat0_q;
        sdat1_d = cap1 ? data1 : sdat1_q;
        wrt_d   = launch;
        gnt0_d  = grant0;
        gnt1_d  = grant1;
        done0_d = finish && !cur_q;
        done1_d = finish && cur_q;
        err_d   = expire;
        ovf0_d  = req0 && !cap0;
        ovf1_d  = req1 && !cap1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            cur_q      <= 1'b0;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            sss0_q     <= '0;
            sss1_q     <= '0;
            sdat0_q    <= '0;
            sdat1_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf0_q     <= 1'b0;
            ovf1_q     <= 1'b0;
            wrt_q      <= 1'b0;
            rdata_q    <= '0;
            spi_data_q <= '0;
            ss_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            sss0_q     <= sss0_d;
            sss1_q     <= sss1_d;
            sdat0_q    <= sdat0_d;
            sdat1_q    <= sdat1_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            ovf0_q     <= ovf0_d;
            ovf1_q     <= ovf1_d;
            wrt_q      <= wrt_d;
            rdata_q    <= rdata_d;
            spi_data_q <= spi_data_d;
            ss_q       <= ss_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign err      = err_q;
    assign ovf0     = ovf0_q;
    assign ovf1     = ovf1_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q == ST_WAIT);
    assign wrt_SPI  = wrt_q;
    assign SPI_data = spi_data_q;
    assign ss       = ss_q;

endmodule
